// File: rtl/seg7_scan_display.sv
// ============================================================================
// Module   : seg7_scan_display
// Brief    : Six-digit common-anode 7-segment scanner for an HH:MM:SS clock
//            with per-frame shadowing, field blink, alarm flash and colon dp.
//            Optional macro COLON_BLINK_EN flashes the colon at the blink rate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_display #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic [7:0] Hours,
  input  logic [7:0] Minutes,
  input  logic [7:0] Seconds,
  input  logic [1:0] SET,
  input  logic       ALERT,
  output logic [7:0] Seg,
  output logic [5:0] An
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] C_FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       C_DIG_LAST = 3'd5;

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       dig_q, dig_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             blink_q, blink_d;
  logic [7:0]       hrs_q, hrs_d, min_q, min_d, sec_q, sec_d;
  logic             first_q;
  logic [7:0]       seg_q, seg_d;
  logic [5:0]       an_q, an_d;

  logic             w_slot_wrap, w_frame_wrap, w_dp_on, w_field_hit;
  logic [3:0]       w_nib;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'd0:    pat = 8'hC0;
      4'd1:    pat = 8'hF9;
      4'd2:    pat = 8'hA4;
      4'd3:    pat = 8'hB0;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h92;
      4'd6:    pat = 8'h82;
      4'd7:    pat = 8'hF8;
      4'd8:    pat = 8'h80;
      4'd9:    pat = 8'h90;
      default: pat = 8'hBF;
    endcase
    return pat;
  endfunction

  always_comb begin
    w_slot_wrap  = (div_q == C_DIV_LAST);
    w_frame_wrap = w_slot_wrap && (dig_q == C_DIG_LAST);

    div_d   = w_slot_wrap ? '0 : div_q + 1'b1;
    dig_d   = dig_q;
    frm_d   = frm_q;
    blink_d = blink_q;
    if (w_slot_wrap) begin
      dig_d = (dig_q == C_DIG_LAST) ? 3'd0 : dig_q + 3'd1;
    end
    if (w_frame_wrap) begin
      if (frm_q == C_FRM_LAST) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    // One snapshot per frame keeps all six digits coherent.
    hrs_d = hrs_q;
    min_d = min_q;
    sec_d = sec_q;
    if (w_frame_wrap || first_q) begin
      hrs_d = Hours;
      min_d = Minutes;
      sec_d = Seconds;
    end

    w_dp_on     = 1'b0;
    w_field_hit = 1'b0;
    case (dig_q)
      3'd0:    begin w_nib = sec_q[3:0]; w_field_hit = (SET == 2'b11); end
      3'd1:    begin w_nib = sec_q[7:4]; w_field_hit = (SET == 2'b11); end
      3'd2:    begin w_nib = min_q[3:0]; w_field_hit = (SET == 2'b10); w_dp_on = 1'b1; end
      3'd3:    begin w_nib = min_q[7:4]; w_field_hit = (SET == 2'b10); end
      3'd4:    begin w_nib = hrs_q[3:0]; w_field_hit = (SET == 2'b01); w_dp_on = 1'b1; end
      default: begin w_nib = hrs_q[7:4]; w_field_hit = (SET == 2'b01); end
    endcase
`ifdef COLON_BLINK_EN
    w_dp_on = w_dp_on && !blink_q;
`endif

    seg_d = seg_decode(w_nib);
    if (w_dp_on) begin
      seg_d[7] = 1'b0;
    end
    if (blink_q && (ALERT || w_field_hit)) begin
      seg_d = 8'hFF;
    end

    // Slot 0 of every digit is a dark gap so the previous digit cannot ghost.
    if (div_q == '0) begin
      an_d  = 6'h3F;
      seg_d = 8'hFF;
    end else begin
      an_d = ~(6'b00_0001 << dig_q);
    end
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      div_q   <= '0;
      dig_q   <= 3'd0;
      frm_q   <= '0;
      blink_q <= 1'b0;
      hrs_q   <= 8'h00;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      first_q <= 1'b1;
      seg_q   <= 8'hFF;
      an_q    <= 6'h3F;
    end else begin
      div_q   <= div_d;
      dig_q   <= dig_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      hrs_q   <= hrs_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      first_q <= 1'b0;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign Seg = seg_q;
  assign An  = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
// ============================================================================
// Module   : tb_seg7_scan_display
// Brief    : Directed self-checking bench for seg7_scan_display (SCAN_DIV=4,
//            BLINK_FRAMES=2: slot 4 clk, frame 24 clk, blink half 48 clk).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_display;

  logic       Clk = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] Hours = 8'h12, Minutes = 8'h34, Seconds = 8'h56;
  logic [1:0] SET = 2'b00;
  logic       ALERT = 1'b0;
  logic [7:0] Seg;
  logic [5:0] An;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  seg7_scan_display #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .Clk(Clk), .RST(RST), .Hours(Hours), .Minutes(Minutes), .Seconds(Seconds),
    .SET(SET), .ALERT(ALERT), .Seg(Seg), .An(An)
  );

  always #5 Clk = ~Clk;

  // Rising edges since reset release; outputs after edge n show slot state n-1.
  always @(posedge Clk or negedge RST) begin
    if (!RST) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Advance to the sample point (#1 after the edge) whose outputs show slot state c.
  task automatic goto(input int c);
    int n = 0;
    while (cyc != c + 1 && n < 5000) begin
      @(posedge Clk); #1; n++;
    end
    if (cyc != c + 1) begin
      compared++; mismatched++;
      $display("FAIL goto_timeout: at cycle %0d, wanted cycle %0d", cyc, c + 1);
    end
  endtask

  // Slot state index of frame f, digit d, div 1.
  function automatic int slot(input int f, input int d);
    return f * 24 + d * 4 + 1;
  endfunction

  task automatic test_reset;
    repeat (3) @(posedge Clk);
    #1;
    compared++;
    if (Seg !== 8'hFF) begin mismatched++; $display("FAIL reset_seg: got %h expected ff", Seg); end
    compared++;
    if (An !== 6'h3F) begin mismatched++; $display("FAIL reset_an: got %h expected 3f", An); end
    @(negedge Clk);
    RST = 1'b1;
  endtask

  task automatic test_scan;
    logic [7:0] seg_tab [6];
    logic [5:0] an_exp;
    seg_tab = '{8'h82, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9};
    for (int c = 0; c < 24; c++) begin
      goto(c);
      an_exp = (c % 4 == 0) ? 6'h3F : ~(6'b1 << (c / 4));
      compared++;
      if (An !== an_exp) begin
        mismatched++; $display("FAIL scan_an[%0d]: got %h expected %h", c, An, an_exp);
      end
      if (c % 4 != 0) begin
        compared++;
        if (Seg !== seg_tab[c / 4]) begin
          mismatched++; $display("FAIL scan_seg[%0d]: got %h expected %h", c, Seg, seg_tab[c / 4]);
        end
      end
    end
  endtask

  task automatic test_shadow;
    goto(slot(1, 0));
    Seconds = 8'h57;
    goto(slot(1, 1));
    compared++;
    if (Seg !== 8'h92) begin mismatched++; $display("FAIL shadow_same_frame_d1: got %h expected 92", Seg); end
    goto(slot(2, 0));
    compared++;
    if (Seg !== 8'hF8) begin mismatched++; $display("FAIL shadow_next_frame_d0: got %h expected f8", Seg); end
    goto(slot(2, 1));
    compared++;
    if (Seg !== 8'h92) begin mismatched++; $display("FAIL shadow_next_frame_d1: got %h expected 92", Seg); end
  endtask

  task automatic test_set_blink;
    goto(slot(3, 0));
    SET = 2'b10;
    goto(slot(3, 1));
    compared++;
    if (Seg !== 8'h92) begin mismatched++; $display("FAIL set_ph1_d1: got %h expected 92", Seg); end
    goto(slot(3, 2));
    compared++;
    if (Seg !== 8'hFF) begin mismatched++; $display("FAIL set_ph1_d2: got %h expected ff", Seg); end
    compared++;
    if (An !== 6'h3B) begin mismatched++; $display("FAIL set_ph1_an2: got %h expected 3b", An); end
    goto(slot(3, 3));
    compared++;
    if (Seg !== 8'hFF) begin mismatched++; $display("FAIL set_ph1_d3: got %h expected ff", Seg); end
    goto(slot(3, 5));
    compared++;
    if (Seg !== 8'hF9) begin mismatched++; $display("FAIL set_ph1_d5: got %h expected f9", Seg); end
    goto(slot(4, 2));
    compared++;
    if (Seg !== 8'h19) begin mismatched++; $display("FAIL set_ph0_d2: got %h expected 19", Seg); end
    goto(slot(4, 3));
    compared++;
    if (Seg !== 8'hB0) begin mismatched++; $display("FAIL set_ph0_d3: got %h expected b0", Seg); end
    SET = 2'b00;
  endtask

  task automatic test_alert;
    goto(slot(5, 5));
    ALERT = 1'b1;
    SET   = 2'b01;
    goto(slot(6, 0));
    compared++;
    if (Seg !== 8'hFF) begin mismatched++; $display("FAIL alert_ph1_d0: got %h expected ff", Seg); end
    goto(slot(6, 2));
    compared++;
    if (Seg !== 8'hFF) begin mismatched++; $display("FAIL alert_ph1_d2: got %h expected ff", Seg); end
    goto(slot(6, 5));
    compared++;
    if (Seg !== 8'hFF) begin mismatched++; $display("FAIL alert_ph1_d5: got %h expected ff", Seg); end
    compared++;
    if (An !== 6'h1F) begin mismatched++; $display("FAIL alert_ph1_an5: got %h expected 1f", An); end
    goto(slot(8, 0));
    compared++;
    if (Seg !== 8'hF8) begin mismatched++; $display("FAIL alert_ph0_d0: got %h expected f8", Seg); end
    goto(slot(8, 4));
    compared++;
    if (Seg !== 8'h24) begin mismatched++; $display("FAIL alert_ph0_d4: got %h expected 24", Seg); end
    goto(slot(8, 5));
    compared++;
    if (Seg !== 8'hF9) begin mismatched++; $display("FAIL alert_ph0_d5: got %h expected f9", Seg); end
    ALERT = 1'b0;
    SET   = 2'b00;
  endtask

  task automatic test_dash;
    goto(slot(9, 1));
    Hours = 8'h1A;
    goto(slot(9, 4));
    compared++;
    if (Seg !== 8'h24) begin mismatched++; $display("FAIL dash_old_frame_d4: got %h expected 24", Seg); end
    goto(slot(12, 4));
    compared++;
    if (Seg !== 8'h3F) begin mismatched++; $display("FAIL dash_d4: got %h expected 3f", Seg); end
    goto(slot(12, 5));
    compared++;
    if (Seg !== 8'hF9) begin mismatched++; $display("FAIL dash_d5: got %h expected f9", Seg); end
  endtask

  task automatic test_colon;
    logic [7:0] exp_d2_ph1, exp_d4_ph1;
`ifdef COLON_BLINK_EN
    exp_d2_ph1 = 8'h99;
    exp_d4_ph1 = 8'hBF;
`else
    exp_d2_ph1 = 8'h19;
    exp_d4_ph1 = 8'h3F;
`endif
    goto(slot(14, 2));
    compared++;
    if (Seg !== exp_d2_ph1) begin mismatched++; $display("FAIL colon_ph1_d2: got %h expected %h", Seg, exp_d2_ph1); end
    goto(slot(14, 4));
    compared++;
    if (Seg !== exp_d4_ph1) begin mismatched++; $display("FAIL colon_ph1_d4: got %h expected %h", Seg, exp_d4_ph1); end
    goto(slot(16, 2));
    compared++;
    if (Seg !== 8'h19) begin mismatched++; $display("FAIL colon_ph0_d2: got %h expected 19", Seg); end
  endtask

  task automatic test_reset_mid;
    goto(slot(17, 3));
    RST = 1'b0;
    #1;
    compared++;
    if (Seg !== 8'hFF) begin mismatched++; $display("FAIL rstmid_async_seg: got %h expected ff", Seg); end
    compared++;
    if (An !== 6'h3F) begin mismatched++; $display("FAIL rstmid_async_an: got %h expected 3f", An); end
    repeat (3) @(posedge Clk);
    #1;
    compared++;
    if (An !== 6'h3F) begin mismatched++; $display("FAIL rstmid_held_an: got %h expected 3f", An); end
    @(negedge Clk);
    RST = 1'b1;
    goto(0);
    compared++;
    if (An !== 6'h3F) begin mismatched++; $display("FAIL rstmid_gap_an: got %h expected 3f", An); end
    goto(1);
    compared++;
    if (An !== 6'h3E) begin mismatched++; $display("FAIL rstmid_first_an: got %h expected 3e", An); end
    compared++;
    if (Seg !== 8'hF8) begin mismatched++; $display("FAIL rstmid_first_seg: got %h expected f8", Seg); end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_shadow;
    test_set_blink;
    test_alert;
    test_dash;
    test_colon;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
